mux_source_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that owns the 4-bit Selection input of the CPU's shared 17-bit three-input/hardwired-constant source mux.
- Three datapath requesters compete for mux inputs 1..3, which map to Selection 0..2.
- A constant-injection port requests one-cycle selection of hardwired constants, Selection 3..5.
- Sits between the control unit and the source mux; downstream consumers qualify mux Output with Valid.

---
 rtl/mux_source_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mux_source_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_source_arbiter.sv
// mux_source_arbiter: round-robin owner of the shared source-mux Selection input.
// Three datapath requesters (Selection 0..2) share the mux with a one-cycle
// hardwired-constant injection (Selection 3..5). All outputs are registered;
// Selection 4'hF is the idle code and only ever appears with Valid low.
module mux_source_arbiter #(
  parameter int MAX_HOLD = 8,  // max tenure while someone else waits, >= 1
  parameter int CNT_W    = 4   // 2**CNT_W must exceed MAX_HOLD
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] Request,
  input  logic       ConstReq,
  input  logic [1:0] ConstSel,
  output logic [2:0] Grant,
  output logic       ConstAck,
  output logic [3:0] Selection,
  output logic       Valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    CONST = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       SEL_IDLE = 4'hF;

  // (base + step) mod 3 for base in 0..2 and step in 0..3
  function automatic logic [1:0] wrap3(input logic [1:0] base, input logic [1:0] step);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    if (sum >= 3'd3) begin
      wrap3 = 2'(sum - 3'd3);
    end else begin
      wrap3 = sum[1:0];
    end
  endfunction

  // First set request searching from ptr+1 mod 3; result is {found, index}
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = 3'b000;
    // walk farthest-to-nearest so the nearest candidate after ptr wins
    for (int k = 3; k >= 1; k--) begin
      idx = wrap3(ptr, 2'(k));
      if (req[idx]) begin
        rr_pick = {1'b1, idx};
      end
    end
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] g);
    case (g)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  // ConstSel 3 aliases constant 5 so Selection never reaches 6..14
  function automatic logic [3:0] const_code(input logic [1:0] sel);
    case (sel)
      2'd0:    const_code = 4'd3;
      2'd1:    const_code = 4'd4;
      default: const_code = 4'd5;
    endcase
  endfunction

  state_t           state_r, state_s;
  logic [1:0]       gidx_r, gidx_s;
  logic [1:0]       ptr_r, ptr_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       req_r;
  logic [2:0]       pick_s, next_pick_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             contend_s, hold_s;
  logic [2:0]       grant_s;
  logic             ack_s, valid_s;
  logic [3:0]       sel_s;

  // Next-state logic: arbitration points are IDLE, tenure end and the CONST cycle
  always_comb begin
    state_s     = state_r;
    gidx_s      = gidx_r;
    ptr_s       = ptr_r;
    cnt_s       = cnt_r;
    pick_s      = rr_pick(Request, ptr_r);
    next_pick_s = rr_pick(Request, gidx_r);
    cnt_inc_s   = (cnt_r == MAX_CNT) ? cnt_r : (cnt_r + CNT_ONE);
    contend_s   = |(Request & ~onehot(gidx_r));
    // holding is judged on last cycle's request, giving the owner one
    // trailing granted cycle after it lowers Request
    hold_s      = req_r[gidx_r] && ((cnt_inc_s != MAX_CNT) || !contend_s);
    case (state_r)
      IDLE: begin
        if (ConstReq) begin
          state_s = CONST;
        end else if (pick_s[2]) begin
          state_s = GRANT;
          gidx_s  = pick_s[1:0];
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (hold_s) begin
          state_s = GRANT;
          // uncontended owner keeps the mux; the tenure counter wraps
          cnt_s   = (cnt_inc_s == MAX_CNT) ? CNT_ZERO : cnt_inc_s;
        end else begin
          ptr_s = gidx_r;
          if (ConstReq) begin
            state_s = CONST;
          end else if (next_pick_s[2]) begin
            state_s = GRANT;
            gidx_s  = next_pick_s[1:0];
            cnt_s   = CNT_ZERO;
          end else begin
            state_s = IDLE;
          end
        end
      end
      CONST: begin
        // ConstReq is ignored here so a held constant request cannot starve requesters
        if (pick_s[2]) begin
          state_s = GRANT;
          gidx_s  = pick_s[1:0];
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    grant_s = 3'b000;
    ack_s   = 1'b0;
    sel_s   = SEL_IDLE;
    valid_s = 1'b0;
    case (state_s)
      GRANT: begin
        grant_s = onehot(gidx_s);
        sel_s   = {2'b00, gidx_s};
        valid_s = 1'b1;
      end
      CONST: begin
        ack_s   = 1'b1;
        sel_s   = const_code(ConstSel);
        valid_s = 1'b1;
      end
      default: begin
        grant_s = 3'b000;
        ack_s   = 1'b0;
        sel_s   = SEL_IDLE;
        valid_s = 1'b0;
      end
    endcase
  end

  // State, arbitration bookkeeping and registered outputs
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r   <= IDLE;
      gidx_r    <= 2'd0;
      ptr_r     <= 2'd2;
      cnt_r     <= CNT_ZERO;
      req_r     <= 3'b000;
      Grant     <= 3'b000;
      ConstAck  <= 1'b0;
      Selection <= SEL_IDLE;
      Valid     <= 1'b0;
    end else begin
      state_r   <= state_s;
      gidx_r    <= gidx_s;
      ptr_r     <= ptr_s;
      cnt_r     <= cnt_s;
      req_r     <= Request;
      Grant     <= grant_s;
      ConstAck  <= ack_s;
      Selection <= sel_s;
      Valid     <= valid_s;
    end
  end

endmodule

// File: tb/tb_mux_source_arbiter.sv
// Scoreboard bench for mux_source_arbiter: each stimulus step queues the
// hand-computed outputs expected in the following cycle; a negedge monitor
// pops and compares them.
module tb_mux_source_arbiter;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [2:0] Request;
  logic       ConstReq;
  logic [1:0] ConstSel;
  logic [2:0] Grant;
  logic       ConstAck;
  logic [3:0] Selection;
  logic       Valid;

  mux_source_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Request  (Request),
    .ConstReq (ConstReq),
    .ConstSel (ConstSel),
    .Grant    (Grant),
    .ConstAck (ConstAck),
    .Selection(Selection),
    .Valid    (Valid)
  );

  // 10 ns clock
  always #5 Clock = ~Clock;

  int cyc = 0;
  // cycle stamp used to align queued expectations
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      nm;
    logic [2:0] g;
    logic       a;
    logic [3:0] s;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic check_out(input string nm, input logic [2:0] eg, input logic ea,
                           input logic [3:0] es);
    logic ev;
    ev = (eg != 3'b000) || ea;
    total_cnt++;
    if (Grant === eg && ConstAck === ea && Selection === es && Valid === ev) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got grant=%b ack=%b sel=%0d valid=%b, want grant=%b ack=%b sel=%0d valid=%b",
               nm, Grant, ConstAck, Selection, Valid, eg, ea, es, ev);
    end
  endtask

  // monitor: compare the DUT against the expectation stamped for this cycle
  always @(negedge Clock) begin : monitor
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      total_cnt++;
      $display("FAIL stale_%s: got no sample, want check in cycle %0d", e.nm, e.cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      check_out(e.nm, e.g, e.a, e.s);
    end
  end

  // apply inputs for this cycle and queue the outputs expected next cycle
  task automatic step(input string nm, input logic [2:0] req, input logic cr,
                      input logic [1:0] cs, input logic [2:0] eg, input logic ea,
                      input logic [3:0] es);
    exp_t e;
    Request  = req;
    ConstReq = cr;
    ConstSel = cs;
    e.cyc = cyc + 1;
    e.nm  = nm;
    e.g   = eg;
    e.a   = ea;
    e.s   = es;
    exp_q.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  task automatic step_g(input string nm, input logic [2:0] req, input logic cr,
                        input logic [1:0] cs, input int g);
    logic [2:0] oh;
    oh = 3'b001;
    oh = oh << g;
    step(nm, req, cr, cs, oh, 1'b0, 4'(g));
  endtask

  task automatic step_i(input string nm, input logic [2:0] req, input logic cr,
                        input logic [1:0] cs);
    step(nm, req, cr, cs, 3'b000, 1'b0, 4'hF);
  endtask

  task automatic step_c(input string nm, input logic [2:0] req, input logic cr,
                        input logic [1:0] cs, input logic [3:0] sel);
    step(nm, req, cr, cs, 3'b000, 1'b1, sel);
  endtask

  // directed stimulus
  initial begin
    Reset    = 1'b0;
    Request  = 3'b000;
    ConstReq = 1'b0;
    ConstSel = 2'd0;
    @(negedge Clock);
    check_out("reset_state", 3'b000, 1'b0, 4'hF);
    Reset = 1'b1;
    @(posedge Clock);
    #1;

    // idle after release
    for (int i = 0; i < 3; i++) step_i($sformatf("idle_%0d", i), 3'b000, 1'b0, 2'd0);

    // all three requesting: 8-cycle tenures rotating 0,1,2,0 from pointer 2
    for (int i = 0; i < 25; i++) step_g($sformatf("rot_%0d", i), 3'b111, 1'b0, 2'd0, (i / 8) % 3);
    step_g("rot_tail", 3'b000, 1'b0, 2'd0, 0);
    step_i("rot_idle", 3'b000, 1'b0, 2'd0);

    // lone requester for 20 cycles keeps the mux for 21, no bubble at wrap
    for (int i = 0; i < 20; i++) step_g($sformatf("solo_%0d", i), 3'b001, 1'b0, 2'd0, 0);
    step_g("solo_tail", 3'b000, 1'b0, 2'd0, 0);
    step_i("solo_idle", 3'b000, 1'b0, 2'd0);

    // ConstReq beats Request from IDLE; ConstSel=1 -> Selection 4
    step_c("cprio_const", 3'b010, 1'b1, 2'd1, 4'd4);
    step_g("cprio_g1", 3'b010, 1'b0, 2'd0, 1);
    step_g("cprio_tail", 3'b000, 1'b0, 2'd0, 1);
    step_i("cprio_idle", 3'b000, 1'b0, 2'd0);

    // ConstReq waits for the tenure boundary; ConstSel=3 -> Selection 5
    step_g("cwait_g0", 3'b001, 1'b0, 2'd0, 0);
    step_g("cwait_nopre1", 3'b001, 1'b1, 2'd3, 0);
    step_g("cwait_nopre2", 3'b001, 1'b1, 2'd3, 0);
    step_g("cwait_tail", 3'b000, 1'b1, 2'd3, 0);
    step_c("cwait_const", 3'b000, 1'b1, 2'd3, 4'd5);
    step_i("cwait_idle", 3'b000, 1'b0, 2'd0);

    // held ConstReq alternates with requester tenures
    step_c("alt_const1", 3'b001, 1'b1, 2'd2, 4'd5);
    step_g("alt_g0a", 3'b001, 1'b1, 2'd0, 0);
    step_g("alt_g0a_tail", 3'b000, 1'b1, 2'd0, 0);
    step_c("alt_const2", 3'b000, 1'b1, 2'd0, 4'd3);
    step_g("alt_g0b", 3'b001, 1'b0, 2'd0, 0);
    step_g("alt_g0b_tail", 3'b000, 1'b0, 2'd0, 0);
    step_i("alt_idle", 3'b000, 1'b0, 2'd0);

    // one-cycle pulse gives two grant cycles; pointer moves to 2
    step_g("pulse_g2", 3'b100, 1'b0, 2'd0, 2);
    step_g("pulse_tail", 3'b000, 1'b0, 2'd0, 2);
    step_i("pulse_idle", 3'b000, 1'b0, 2'd0);
    for (int i = 0; i < 8; i++) step_g($sformatf("ptr2_g0_%0d", i), 3'b011, 1'b0, 2'd0, 0);
    step_g("ptr2_g1", 3'b011, 1'b0, 2'd0, 1);
    step_g("ptr2_tail", 3'b000, 1'b0, 2'd0, 1);
    step_i("ptr2_idle", 3'b000, 1'b0, 2'd0);

    // asynchronous reset in the middle of a tenure
    step_g("arst_g0a", 3'b001, 1'b0, 2'd0, 0);
    step_g("arst_g0b", 3'b001, 1'b0, 2'd0, 0);
    @(negedge Clock);
    #1;
    Reset   = 1'b0;
    Request = 3'b111;
    #1;
    check_out("arst_immediate", 3'b000, 1'b0, 4'hF);
    @(posedge Clock);
    #1;
    check_out("arst_held", 3'b000, 1'b0, 4'hF);
    @(negedge Clock);
    Reset   = 1'b1;
    Request = 3'b000;
    @(posedge Clock);
    #1;
    step_i("arst_idle", 3'b000, 1'b0, 2'd0);
    // pointer is back at 2, so 110 picks requester 1 first
    step_g("arst_ptr_g1", 3'b110, 1'b0, 2'd0, 1);
    step_g("arst_ptr_tail", 3'b000, 1'b0, 2'd0, 1);
    step_i("arst_ptr_idle", 3'b000, 1'b0, 2'd0);
    step_i("final_idle", 3'b000, 1'b0, 2'd0);

    // bounded drain of the scoreboard
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge Clock);
    @(negedge Clock);
    #1;
    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
